// File: rtl/mdu_seq_if.sv
// Request/response bus of the sequential multiply/divide unit.
// The slave modport is the unit; the master modport is the requester/consumer.
interface mdu_seq_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport slave (
    input  req_valid, op, rs1, rs2, resp_ready,
    output req_ready, resp_valid, result, busy
  );

  modport master (
    output req_valid, op, rs1, rs2, resp_ready,
    input  req_ready, resp_valid, result, busy
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32 M-extension unit: shift-add multiply / restoring divide on
// operand magnitudes, sign fix-up in a single cycle, ready/valid handshakes.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mdu_seq_if.slave  bus
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST    = 6'(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand sign decode and magnitude conversion at accept time
  logic            s1, s2, neg1, neg2, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2;

  assign s1     = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                  (bus.op == OP_DIV)  || (bus.op == OP_REM);
  assign s2     = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign neg1   = s1 & bus.rs1[XLEN-1];
  assign neg2   = s2 & bus.rs2[XLEN-1];
  assign mag1   = neg1 ? -bus.rs1 : bus.rs1;
  assign mag2   = neg2 ? -bus.rs2 : bus.rs2;
  assign neg_in = (bus.op == OP_REM) ? neg1 : (neg1 ^ neg2);

  assign div_zero = bus.op[2] && (bus.rs2 == '0);
  assign div_ovf  = bus.op[2] && !bus.op[0] && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);

  // Datapath step values
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign div_shift = {rem_q, quot_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_sub   = div_shift[XLEN-1:0] - b_q;
  assign prod_fix  = neg_q ? -prod_q : prod_q;
  assign quot_fix  = neg_q ? -quot_q : quot_q;
  assign rem_fix   = neg_q ? -rem_q  : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        op_d   = bus.op;
        neg_d  = neg_in;
        a_d    = mag1;
        b_d    = mag2;
        cnt_d  = '0;
        prod_d = {{XLEN{1'b0}}, mag2};
        quot_d = mag1;
        rem_d  = '0;
        if (div_zero) begin
          result_d = bus.op[1] ? bus.rs1 : '1;
          state_d  = DONE;
        end else if (div_ovf) begin
          result_d = bus.op[1] ? '0 : INT_MIN;
          state_d  = DONE;
        end else begin
          state_d  = CALC;
        end
      end
      // 32 working iterations, then one idle count step hands over to FIX
      CALC: if (cnt_q == LAST) begin
        state_d = FIX;
      end else begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[2]) begin
          quot_d = {quot_q[XLEN-2:0], div_ge};
          rem_d  = div_ge ? div_sub : div_shift[XLEN-1:0];
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
      end
      FIX: begin
        case (op_q)
          OP_MUL:                  result_d = prod_fix[XLEN-1:0];
          3'b001, 3'b010, 3'b011:  result_d = prod_fix[2*XLEN-1:XLEN];
          3'b100, 3'b101:          result_d = quot_fix;
          default:                 result_d = rem_fix;
        endcase
        state_d = DONE;
      end
      DONE: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.result     = (state_q == DONE) ? result_q : '0;

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  unit can accept an operation.
REQ-006 op  input  3  M-extension opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1  input  32  first operand (dividend / multiplicand).
REQ-008 rs2  input  32  second operand (divisor / multiplier).
REQ-009 resp_valid  output  1  result is available.
REQ-010 resp_ready  input  1  consumer accepts the result.
REQ-011 result  output  32  operation result.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The unit SHALL implement the FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-014 req_ready SHALL be 1 only in IDLE; an accept is req_valid && req_ready at a rising edge.
REQ-015 On accept, op, rs1 and rs2 SHALL be captured; later changes on the inputs SHALL have no effect.
REQ-016 Signed handling: DIV, REM, MULH SHALL treat both operands as signed; MULHSU SHALL treat rs1 as signed and rs2 as unsigned; MULHU, DIVU, REMU SHALL treat both as unsigned; MUL SHALL return the low word, which is identical for any signedness.
REQ-017 Signed operands SHALL be converted to magnitudes at accept, and the negate flag SHALL be recorded: for multiply, the XOR of the operand signs; for DIV, the XOR of the signs; for REM, the sign of rs1.
REQ-018 CALC SHALL perform exactly 32 iterations, one per edge, using a 6-bit counter: shift-add multiply into a 64-bit product, or restoring divide producing a 32-bit quotient and remainder.
REQ-019 FIX SHALL take one cycle: two's-complement negate the 64-bit product, quotient or remainder if the negate flag is set, then select the result.
REQ-020 Result selection: MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32]; DIV and DIVU take the quotient; REM and REMU take the remainder.
REQ-021 Normal latency: resp_valid SHALL rise 34 rising edges after the accept edge.
REQ-022 Fast path, rs2 == 0 on DIV/DIVU/REM/REMU: the FSM SHALL go IDLE -> DONE directly, with 1-edge latency. The quotient SHALL be 0xFFFFFFFF; the remainder SHALL be rs1.
REQ-023 Fast path, DIV/REM with rs1 == 0x80000000 and rs2 == 0xFFFFFFFF: the FSM SHALL go directly to DONE with 1-edge latency. DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-024 In DONE, resp_valid SHALL be 1, and result SHALL stay stable until resp_valid && resp_ready; on that edge the FSM SHALL go to IDLE.
REQ-025 No new request SHALL be accepted on the edge that completes a response; the earliest next accept is the following edge.
REQ-026 resp_valid SHALL be 0 in IDLE, CALC and FIX, and result SHALL be 0 outside DONE.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state IDLE, counter 0, product, quotient and remainder registers 0, result 0, resp_valid 0, busy 0, and req_ready 1.
REQ-028 Reset asserted mid-CALC or mid-DONE SHALL abort the operation with no response ever emitted for it.
REQ-029 After rst_n deasserts, the first accept SHALL be possible on the next rising edge.

Verification
REQ-030 MUL: rs1 = 7, rs2 = 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, resp_valid 34 edges after accept; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
REQ-033 Divide by zero: DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 % 0 -> 5, each with 1-edge latency; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, with 1-edge latency.
REQ-034 Backpressure: hold resp_ready low for 10 cycles in DONE -> result and resp_valid stay constant, and req_ready stays 0 throughout; a request presented the same edge as the handoff is accepted only on the next edge.
REQ-035 Reset during CALC iteration 15 -> all outputs at reset values immediately; no resp_valid pulse; a new DIVU 9 / 3 after release -> 3.
